// File: rtl/pol_comma_pkg.sv
// Polarity-comma symbol constants and FSM state encoding shared by the TX
// inserter and the RX polarity adjuster so both ends stay in step.
package pol_comma_pkg;

  localparam logic [9:0] COMMA_POS     = 10'b10_1011_1100;
  localparam logic [9:0] COMMA_NEG     = 10'b10_0100_0011;
  localparam logic [9:0] ORI_COMMA_POS = 10'b01_0111_1100;
  localparam logic [9:0] ORI_COMMA_NEG = ~ORI_COMMA_POS;

  typedef enum logic [1:0] {
    ST_DIS   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PEND  = 2'd2,
    ST_BURST = 2'd3
  } pol_state_e;

  function automatic logic is_k285(input logic [9:0] sym);
    return (sym == ORI_COMMA_POS) || (sym == ORI_COMMA_NEG);
  endfunction

endpackage

// File: rtl/tx_pol_comma_ins_if.sv
// Upstream valid/ready symbol handshake into the polarity comma inserter.
interface tx_pol_comma_ins_if;
  logic [9:0] i_data;
  logic       i_vld;
  logic       o_rdy;

  modport master (output i_data, output i_vld, input  o_rdy);
  modport slave  (input  i_data, input  i_vld, output o_rdy);
endinterface

// File: rtl/tx_pol_sym_map.sv
// Combinational K28.5 -> polarity comma mapping; transparent when disabled.
module tx_pol_sym_map
  import pol_comma_pkg::*;
(
  input  logic       i_map_en,
  input  logic [9:0] i_sym,
  output logic [9:0] o_sym
);

  always_comb begin
    o_sym = i_sym;
    if (i_map_en) begin
      if (i_sym == ORI_COMMA_POS)      o_sym = COMMA_POS;
      else if (i_sym == ORI_COMMA_NEG) o_sym = COMMA_NEG;
    end
  end

endmodule

// File: rtl/tx_pol_comma_ins.sv
// TX polarity comma inserter: maps K28.5 to polarity commas, injects periodic
// alternating comma bursts while stalling upstream, fills idle with commas.
module tx_pol_comma_ins
  import pol_comma_pkg::*;
#(
  parameter int unsigned INS_PERIOD = 1024,
  parameter int unsigned BURST_NUM  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pol_ins_en,
  input  logic                i_force_burst,
  input  logic                i_tx_inv,
  tx_pol_comma_ins_if.slave   up,
  output logic [9:0]          o_data,
  output logic                o_burst
);

  localparam int unsigned PW = $clog2(INS_PERIOD);
  localparam int unsigned BW = $clog2(BURST_NUM);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(INS_PERIOD - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_NUM - 1);

  pol_state_e    state;
  logic [PW-1:0] period_cnt;
  logic [BW-1:0] burst_cnt;
  logic          fill_tog;

  logic       xfer;
  logic       burst_act;
  logic       fill_use;
  logic       map_en;
  logic [9:0] raw_sym;
  logic [9:0] mapped_sym;
  logic [9:0] sym;

  assign up.o_rdy = (state != ST_BURST) && !i_rst;

  // A disable arriving during BURST takes priority: that cycle already emits
  // raw fill rather than a burst symbol, so the abort is visible immediately.
  always_comb begin
    xfer      = up.i_vld && up.o_rdy;
    burst_act = i_pol_ins_en && (state == ST_BURST);
    fill_use  = !burst_act && !xfer;
    map_en    = i_pol_ins_en && ((state == ST_WAIT) || (state == ST_PEND));
    raw_sym   = xfer ? up.i_data : (fill_tog ? ORI_COMMA_NEG : ORI_COMMA_POS);
    sym       = mapped_sym;
    if (burst_act) sym = burst_cnt[0] ? COMMA_NEG : COMMA_POS;
  end

  tx_pol_sym_map u_sym_map (
    .i_map_en (map_en),
    .i_sym    (raw_sym),
    .o_sym    (mapped_sym)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_DIS;
      period_cnt <= '0;
      burst_cnt  <= '0;
      fill_tog   <= 1'b0;
      o_data     <= ORI_COMMA_POS;
      o_burst    <= 1'b0;
    end else begin
      o_data  <= i_tx_inv ? ~sym : sym;
      o_burst <= burst_act;
      if (fill_use) fill_tog <= ~fill_tog;

      if (!i_pol_ins_en) begin
        state      <= ST_DIS;
        period_cnt <= '0;
        burst_cnt  <= '0;
      end else begin
        unique case (state)
          ST_DIS: begin
            state     <= ST_BURST;
            burst_cnt <= '0;
          end
          ST_WAIT: begin
            period_cnt <= period_cnt + PW'(1);
            if ((period_cnt == PERIOD_LAST) || i_force_burst) state <= ST_PEND;
          end
          ST_PEND: begin
            if (!up.i_vld || (xfer && is_k285(up.i_data))) begin
              state     <= ST_BURST;
              burst_cnt <= '0;
            end
          end
          ST_BURST: begin
            if (burst_cnt == BURST_LAST) begin
              state      <= ST_WAIT;
              period_cnt <= '0;
              burst_cnt  <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
          default: state <= ST_DIS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_pol_comma_ins.sv
// Directed bench for tx_pol_comma_ins with hand-computed expected symbols.
module tb_tx_pol_comma_ins;

  logic       clk;
  logic       rst;
  logic       en;
  logic       frc;
  logic       inv;
  logic [9:0] o_data;
  logic       o_burst;

  int unsigned errors = 0;
  int unsigned checks = 0;

  tx_pol_comma_ins_if up_if ();

  tx_pol_comma_ins #(
    .INS_PERIOD (1024),
    .BURST_NUM  (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pol_ins_en  (en),
    .i_force_burst (frc),
    .i_tx_inv      (inv),
    .up            (up_if),
    .o_data        (o_data),
    .o_burst       (o_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 32 burst cycles: alternating commas, stalled upstream until the final one.
  task automatic run_burst(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk({tag, "_burst"}, 32'(o_burst), 32'd1);
      chk({tag, "_sym"}, 32'(o_data), (i % 2 == 0) ? 32'h2BC : 32'h243);
      chk({tag, "_rdy"}, 32'(up_if.o_rdy), (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; frc = 1'b0; inv = 1'b0;
    up_if.i_vld = 1'b0; up_if.i_data = '0;
    tick(); tick();
    chk("rst_data", 32'(o_data), 32'h17C);
    chk("rst_burst", 32'(o_burst), 32'd0);
    chk("rst_rdy", 32'(up_if.o_rdy), 32'd0);

    // disabled: raw pass-through, unmapped fill
    rst = 1'b0; up_if.i_vld = 1'b1; up_if.i_data = 10'h17C; #1;
    chk("dis_rdy", 32'(up_if.o_rdy), 32'd1);
    tick(); chk("dis_k285_raw", 32'(o_data), 32'h17C);
    up_if.i_data = 10'h1A5;
    tick(); chk("dis_data", 32'(o_data), 32'h1A5);
    up_if.i_vld = 1'b0;
    tick(); chk("dis_fill0", 32'(o_data), 32'h17C);
    tick(); chk("dis_fill1", 32'(o_data), 32'h283);
    chk("dis_noburst", 32'(o_burst), 32'd0);

    // startup burst
    en = 1'b1;
    tick();
    chk("start_sym", 32'(o_data), 32'h17C);
    chk("start_rdy", 32'(up_if.o_rdy), 32'd0);
    run_burst("start");
    tick(); chk("wait_fill0", 32'(o_data), 32'h243);
    chk("wait_noburst", 32'(o_burst), 32'd0);
    tick(); chk("wait_fill1", 32'(o_data), 32'h2BC);
    repeat (8) tick();

    // forced burst at period counter 10
    frc = 1'b1;
    tick(); frc = 1'b0;
    chk("frc_fill", 32'(o_data), 32'h243);
    chk("frc_rdy", 32'(up_if.o_rdy), 32'd1);
    tick();
    chk("pend_fill", 32'(o_data), 32'h2BC);
    chk("pend_burst0", 32'(o_burst), 32'd0);
    chk("pend_rdy", 32'(up_if.o_rdy), 32'd0);
    up_if.i_vld = 1'b1; up_if.i_data = 10'h0F0;
    run_burst("frc");
    tick(); chk("resume_data", 32'(o_data), 32'h0F0);

    // periodic request: PEND exactly at period counter 1023
    up_if.i_data = 10'h1A5;
    repeat (1022) tick();
    chk("steady_data", 32'(o_data), 32'h1A5);
    up_if.i_vld = 1'b0;
    tick();
    chk("gap_in_wait_sym", 32'(o_data), 32'h243);
    chk("gap_in_wait_rdy", 32'(up_if.o_rdy), 32'd1);
    up_if.i_vld = 1'b1;
    tick();
    chk("pend_data", 32'(o_data), 32'h1A5);
    chk("pend_hold_rdy", 32'(up_if.o_rdy), 32'd1);
    up_if.i_vld = 1'b0;
    tick();
    chk("pend_gap_sym", 32'(o_data), 32'h2BC);
    chk("pend_gap_rdy", 32'(up_if.o_rdy), 32'd0);
    up_if.i_vld = 1'b1; up_if.i_data = 10'h155;
    run_burst("per");
    tick(); chk("per_resume", 32'(o_data), 32'h155);

    // K28.5 mapping of accepted data
    up_if.i_data = 10'h17C;
    tick(); chk("map_pos", 32'(o_data), 32'h2BC);
    up_if.i_data = 10'h283;
    tick(); chk("map_neg", 32'(o_data), 32'h243);

    // accepted K28.5 in PEND launches the burst
    up_if.i_data = 10'h1A5; frc = 1'b1;
    tick(); frc = 1'b0;
    chk("kpend_rdy0", 32'(up_if.o_rdy), 32'd1);
    chk("kpend_data0", 32'(o_data), 32'h1A5);
    tick(); chk("kpend_rdy1", 32'(up_if.o_rdy), 32'd1);
    up_if.i_data = 10'h283;
    tick();
    chk("kpend_sym", 32'(o_data), 32'h243);
    chk("kpend_rdy2", 32'(up_if.o_rdy), 32'd0);

    // inverted burst symbols, then disable at burst symbol 5
    inv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("inv_burst", 32'(o_burst), 32'd1);
      chk("inv_sym", 32'(o_data), (i % 2 == 0) ? 32'h143 : 32'h1BC);
    end
    en = 1'b0; inv = 1'b0; up_if.i_data = 10'h1A5;
    tick();
    chk("abort_burst", 32'(o_burst), 32'd0);
    chk("abort_rdy", 32'(up_if.o_rdy), 32'd1);
    chk("abort_sym", 32'(o_data), 32'h283);
    tick(); chk("abort_pass", 32'(o_data), 32'h1A5);
    up_if.i_data = 10'h17C;
    tick(); chk("abort_raw_k", 32'(o_data), 32'h17C);

    // reset mid-burst
    en = 1'b1; up_if.i_vld = 1'b0;
    tick(); tick(); tick();
    chk("mid_burst", 32'(o_burst), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_rdy", 32'(up_if.o_rdy), 32'd0);
    tick();
    chk("mid_rst_data", 32'(o_data), 32'h17C);
    chk("mid_rst_burst", 32'(o_burst), 32'd0);
    rst = 1'b0; en = 1'b0;
    tick();
    chk("post_rst_burst", 32'(o_burst), 32'd0);
    chk("post_rst_rdy", 32'(up_if.o_rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
